ntt_loader: RTL and testbench
=============================

NTT_LOADER -- requirements
Module: ntt_loader

Interface
REQ-001 Parameter N, default 8: coefficients per frame; the fill counter is 3 bits wide.
REQ-002 Parameter CW, default 4: coefficient width in bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 clr  input  1  synchronous frame flush.
REQ-006 in_valid  input  1  upstream coefficient valid.
REQ-007 in_ready  output  1  loader can accept a coefficient.
REQ-008 in_coef  input  [0:3]  coefficient; bit 0 is the MSB on all vector ports.
REQ-009 in_q  input  [0:7]  modulus; sampled with coefficient 0 only.
REQ-010 in_w  input  [0:4]  root of unity; sampled with coefficient 0 only.
REQ-011 out_valid  output  1  full frame presented.
REQ-012 out_ready  input  1  NTT stage consumes the frame.
REQ-013 a1..a8  output  [0:3] each  frame coefficients, in arrival order.
REQ-014 q, w  output  [0:7], [0:4]  captured modulus and root for the frame.
REQ-015 range_err  output  1  at least one frame coefficient was >= q.
REQ-016 q_err  output  1  one-cycle pulse: frame start rejected.
REQ-017 fill  output  [0:2]  number of coefficients held while filling.

Function
REQ-018 FSM states: IDLE, FILL, FULL; the state SHALL be registered.
REQ-019 in_ready SHALL be 1 in IDLE and FILL, and 0 in FULL.
REQ-020 A coefficient is accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-021 IDLE, accept with in_q>=2: store coefficient in a1, capture q and w, set fill=1, go to FILL.
REQ-022 IDLE, accept with in_q<2: drop the coefficient, pulse q_err for 1 cycle, stay in IDLE, leave a1..a8, q, w unchanged.
REQ-023 FILL, accept: store the coefficient in slot fill+1 and increment fill; in_q and in_w are ignored.
REQ-024 When the 8th coefficient is accepted, go to FULL with fill=0; out_valid SHALL be 1 from the next cycle.
REQ-025 range_err is cleared at frame start; it is set if any accepted coefficient, compared as unsigned, is >= the captured q (for coefficient 0, the incoming in_q).
REQ-026 FULL: a1..a8, q, w and range_err SHALL be held stable while out_valid=1.
REQ-027 FULL with out_ready=1: go to IDLE; out_valid is 0 from the next cycle; a1..a8 keep their stale values.
REQ-028 Latency: the frame is presented 1 cycle after the 8th accept. There is 1 bubble cycle after the frame is consumed before the next coefficient can be accepted.
REQ-029 out_ready while not FULL is ignored.
REQ-030 clr=1 in any state: go to IDLE, fill=0, out_valid=0, range_err=0. An in_valid on the same cycle is not accepted. clr takes priority over every other transition.
REQ-031 in_valid=0 in FILL: hold all state; there is no timeout.

Reset
REQ-032 rst asserted SHALL force state IDLE, fill=0, out_valid=0, q_err=0, range_err=0, a1..a8=0, q=0, w=0, independent of clk.
REQ-033 Reset asserted mid-frame or in FULL discards the frame; after release, the first accepted coefficient is treated as coefficient 0.
REQ-034 in_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-035 Basic frame: q=17, w=2, stream 1..8 back-to-back, out_ready=1 -> out_valid=1 for 1 cycle, 1 cycle after the 8th accept, with a1..a8=1..8, q=17, w=2, range_err=0.
REQ-036 Backpressure: out_ready=0 for 5 cycles while FULL -> in_ready=0 and outputs stable throughout; out_ready=1 -> IDLE next cycle; next frame accepted 1 cycle later.
REQ-037 Bad modulus: first coefficient presented with in_q=1 -> q_err pulses once, no store, in_ready stays 1; a following start with in_q=7 is accepted.
REQ-038 Range: q=7, coefficient 4 = 9 -> range_err=1 with the frame; the next frame with all coefficients <7 -> range_err=0.
REQ-039 Flush: 3 coefficients, then clr=1 together with in_valid=1 -> fill=0, that coefficient dropped; the next accept lands in a1 with newly captured q and w.
REQ-040 Async reset: rst pulsed between clock edges while in FULL -> out_valid=0 immediately and all outputs zero before the next edge.

Source files
------------

// File: rtl/ntt_loader.sv
// ntt_loader: gathers an N-coefficient frame plus its modulus and root of unity,
// then holds the frame for the NTT stage until it is consumed.
module ntt_loader #(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [0:CW-1] in_coef,
    input  logic [0:7]    in_q,
    input  logic [0:4]    in_w,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [0:CW-1] a1,
    output logic [0:CW-1] a2,
    output logic [0:CW-1] a3,
    output logic [0:CW-1] a4,
    output logic [0:CW-1] a5,
    output logic [0:CW-1] a6,
    output logic [0:CW-1] a7,
    output logic [0:CW-1] a8,
    output logic [0:7]    q,
    output logic [0:4]    w,
    output logic          range_err,
    output logic          q_err,
    output logic [0:2]    fill
);
    typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

    state_t        state_q, state_d;
    logic [0:2]    fill_q, fill_d;
    logic [0:7]    q_q, q_d;
    logic [0:4]    w_q, w_d;
    logic          rerr_q, rerr_d;
    logic          qerr_q, qerr_d;
    logic [0:CW-1] coef_q [N];
    logic [0:CW-1] coef_d [N];
    logic [0:7]    coef_ext;
    logic          accept;
    logic          last;

    assign coef_ext  = 8'(in_coef);
    assign in_ready  = state_q != FULL;
    assign out_valid = state_q == FULL;
    assign accept    = in_valid && in_ready && !clr;
    assign last      = fill_q == 3'(N - 1);

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        q_d     = q_q;
        w_d     = w_q;
        rerr_d  = rerr_q;
        qerr_d  = 1'b0;
        coef_d  = coef_q;
        if (clr) begin
            state_d = IDLE;
            fill_d  = '0;
            rerr_d  = 1'b0;
        end else if (state_q == IDLE && accept) begin
            // a modulus below 2 cannot define a ring, so the frame start is refused
            if (in_q < 8'd2) begin
                qerr_d = 1'b1;
            end else begin
                coef_d[0] = in_coef;
                q_d       = in_q;
                w_d       = in_w;
                fill_d    = 3'd1;
                rerr_d    = coef_ext >= in_q;
                state_d   = FILL;
            end
        end else if (state_q == FILL && accept) begin
            coef_d[fill_q] = in_coef;
            rerr_d         = rerr_q || (coef_ext >= q_q);
            state_d        = last ? FULL : FILL;
            fill_d         = last ? 3'd0 : fill_q + 3'd1;
        end else if (state_q == FULL && out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            fill_q  <= '0;
            q_q     <= '0;
            w_q     <= '0;
            rerr_q  <= 1'b0;
            qerr_q  <= 1'b0;
            coef_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            q_q     <= q_d;
            w_q     <= w_d;
            rerr_q  <= rerr_d;
            qerr_q  <= qerr_d;
            coef_q  <= coef_d;
        end
    end

    assign a1        = coef_q[0];
    assign a2        = coef_q[1];
    assign a3        = coef_q[2];
    assign a4        = coef_q[3];
    assign a5        = coef_q[4];
    assign a6        = coef_q[5];
    assign a7        = coef_q[6];
    assign a8        = coef_q[7];
    assign q         = q_q;
    assign w         = w_q;
    assign range_err = rerr_q;
    assign q_err     = qerr_q;
    assign fill      = fill_q;
endmodule

// File: tb/tb_ntt_loader.sv
// tb_ntt_loader: directed and random frames checked against a frame-level model.
module tb_ntt_loader;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [0:3] in_coef = '0;
    logic [0:7] in_q = '0;
    logic [0:4] in_w = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [0:3] a1, a2, a3, a4, a5, a6, a7, a8;
    logic [0:7] q;
    logic [0:4] w;
    logic       range_err;
    logic       q_err;
    logic [0:2] fill;

    int total = 0;
    int bad = 0;

    // frame-level reference model
    int         m_frame [$];
    logic       m_full;
    logic [7:0] m_q;
    logic [4:0] m_w;
    logic       m_rerr;
    logic       m_qerr;
    logic [3:0] m_a [8];

    ntt_loader dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_coef(in_coef), .in_q(in_q), .in_w(in_w), .out_valid(out_valid),
        .out_ready(out_ready), .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5),
        .a6(a6), .a7(a7), .a8(a8), .q(q), .w(w), .range_err(range_err),
        .q_err(q_err), .fill(fill)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_frame.delete();
        m_full = 1'b0;
        m_q    = '0;
        m_w    = '0;
        m_rerr = 1'b0;
        m_qerr = 1'b0;
        for (int i = 0; i < 8; i++) m_a[i] = '0;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] ea;
        ea = '0;
        for (int i = 0; i < 8; i++) ea = {ea[27:0], m_a[i]};
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_full));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(!m_full));
        chk({tag, ".fill"}, 32'(fill), 32'(m_frame.size()));
        chk({tag, ".q_err"}, 32'(q_err), 32'(m_qerr));
        chk({tag, ".range_err"}, 32'(range_err), 32'(m_rerr));
        chk({tag, ".q"}, 32'(q), 32'(m_q));
        chk({tag, ".w"}, 32'(w), 32'(m_w));
        chk({tag, ".a"}, {a1, a2, a3, a4, a5, a6, a7, a8}, ea);
    endtask

    task automatic cyc(input string tag, input logic v, input logic [3:0] c, input logic [7:0] qv,
                       input logic [4:0] wv, input logic ordy, input logic cl);
        in_valid  = v;
        in_coef   = c;
        in_q      = qv;
        in_w      = wv;
        out_ready = ordy;
        clr       = cl;
        m_qerr    = 1'b0;
        if (cl) begin
            m_frame.delete();
            m_full = 1'b0;
            m_rerr = 1'b0;
        end else if (m_full) begin
            if (ordy) m_full = 1'b0;
        end else if (v) begin
            if (m_frame.size() == 0 && qv < 2) begin
                m_qerr = 1'b1;
            end else begin
                if (m_frame.size() == 0) begin
                    m_q    = qv;
                    m_w    = wv;
                    m_rerr = 1'b0;
                end
                m_rerr = m_rerr || (8'(c) >= m_q);
                m_frame.push_back(int'(c));
                m_a[m_frame.size() - 1] = c;
                if (m_frame.size() == 8) begin
                    m_full = 1'b1;
                    m_frame.delete();
                end
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b1;
        #1 check_all("reset");
        @(negedge clk);
        rst = 1'b0;
        #1 chk("ready_after_reset", 32'(in_ready), 32'd1);

        // basic frame, back-to-back, consumed immediately
        cyc("basic", 1'b1, 4'd1, 8'd17, 5'd2, 1'b1, 1'b0);
        for (int i = 2; i <= 8; i++) cyc("basic", 1'b1, 4'(i), 8'd0, 5'd0, 1'b1, 1'b0);
        chk("basic_valid", 32'(out_valid), 32'd1);
        chk("basic_a", {a1, a2, a3, a4, a5, a6, a7, a8}, 32'h12345678);
        chk("basic_qw", {19'd0, q, w}, {19'd0, 8'd17, 5'd2});
        cyc("basic_done", 1'b0, 4'd0, 8'd0, 5'd0, 1'b1, 1'b0);
        chk("basic_one_cycle", 32'(out_valid), 32'd0);

        // backpressure: full frame held while the stage stalls
        for (int i = 0; i < 8; i++) cyc("bp_fill", 1'b1, 4'($urandom_range(0, 15)), 8'd200, 5'd9, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc("bp_hold", 1'b1, 4'hf, 8'd3, 5'd1, 1'b0, 1'b0);
        cyc("bp_consume", 1'b0, 4'd0, 8'd0, 5'd0, 1'b1, 1'b0);
        chk("bp_idle", 32'(out_valid), 32'd0);
        cyc("bp_next", 1'b1, 4'd6, 8'd50, 5'd4, 1'b0, 1'b0);
        chk("bp_next_fill", 32'(fill), 32'd1);
        cyc("bp_flush", 1'b0, 4'd0, 8'd0, 5'd0, 1'b0, 1'b1);

        // bad modulus rejected, then a valid start
        cyc("badq", 1'b1, 4'd3, 8'd1, 5'd7, 1'b0, 1'b0);
        chk("badq_pulse", 32'(q_err), 32'd1);
        cyc("badq_after", 1'b0, 4'd0, 8'd0, 5'd0, 1'b0, 1'b0);
        chk("badq_once", 32'(q_err), 32'd0);
        cyc("goodq", 1'b1, 4'd3, 8'd7, 5'd5, 1'b0, 1'b0);
        chk("goodq_q", 32'(q), 32'd7);

        // range error on coefficient index 4, clean frame afterwards
        for (int i = 1; i < 8; i++) cyc("range", 1'b1, (i == 4) ? 4'd9 : 4'(i % 7), 8'd0, 5'd0, 1'b0, 1'b0);
        chk("range_set", 32'(range_err), 32'd1);
        cyc("range_consume", 1'b0, 4'd0, 8'd0, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cyc("range_clean", 1'b1, 4'(i % 7), 8'd7, 5'd1, 1'b1, 1'b0);
        chk("range_clear", 32'(range_err), 32'd0);
        cyc("range_consume2", 1'b0, 4'd0, 8'd0, 5'd0, 1'b1, 1'b0);

        // flush mid-frame with a coefficient on the same cycle
        for (int i = 0; i < 3; i++) cyc("flush_fill", 1'b1, 4'(i + 10), 8'd90, 5'd11, 1'b0, 1'b0);
        cyc("flush", 1'b1, 4'd13, 8'd90, 5'd11, 1'b0, 1'b1);
        chk("flush_fill0", 32'(fill), 32'd0);
        cyc("flush_restart", 1'b1, 4'd2, 8'd33, 5'd21, 1'b0, 1'b0);
        chk("flush_a1", {a1, q, w}, {4'd2, 8'd33, 5'd21});

        // random traffic
        for (int i = 0; i < 600; i++)
            cyc("rand", $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 1)) : 8'($urandom_range(2, 255)),
                5'($urandom_range(0, 31)), $urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0);

        // asynchronous reset while a frame is presented
        cyc("ar_clear", 1'b0, 4'd0, 8'd0, 5'd0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cyc("ar_fill", 1'b1, 4'(i + 3), 8'd60, 5'd17, 1'b0, 1'b0);
        chk("ar_full", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        #1 check_all("async_reset");
        @(negedge clk);
        rst = 1'b0;
        cyc("ar_restart", 1'b1, 4'd5, 8'd9, 5'd3, 1'b0, 1'b0);
        chk("ar_first", {a1, fill}, {4'd5, 3'd1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
